ex_mem_stage: RTL and testbench
===============================

// Module: ex_mem_stage
// PURPOSE
//  EX->MEM pipeline stage directly downstream of the ALU. Captures ALUOut, IsLessThan and EX control
//  into a 2-entry skid buffer, giving a full valid/ready handshake toward the memory stage.
//  Resolves blt branches and issues a one-cycle PC redirect. Drives the EX-side forwarding path
//  back to the ALU operand muxes.
// PARAMETERS
//  REG_WIDTH  32  datapath width of ALU result, store data, PC and immediate
// PORTS
//  clock            in   1          single clock; all state updates on rising edge
//  reset            in   1          synchronous, active-high
//  flush            in   1          kill all held entries and the pending redirect
//  in_valid         in   1          EX presents an instruction
//  in_ready         out  1          stage can accept; registered, equals !(count==2)
//  in_alu_out       in   REG_WIDTH  ALU result
//  in_is_less_than  in   1          ALU compare flag (ALUCtl 0111)
//  in_rs2_data      in   REG_WIDTH  store data
//  in_rd            in   5          destination register
//  in_reg_write     in   1          write-back enable
//  in_mem_read      in   1          load
//  in_mem_write     in   1          store
//  in_branch        in   1          blt instruction
//  in_pc            in   REG_WIDTH  PC of instruction
//  in_imm           in   REG_WIDTH  branch offset, sign-extended
//  out_valid        out  1          head entry valid to MEM
//  out_ready        in   1          MEM accepts head
//  out_alu_out      out  REG_WIDTH  head ALU result / memory address
//  out_rs2_data     out  REG_WIDTH  head store data
//  out_rd           out  5          head destination
//  out_reg_write    out  1          head write-back enable
//  out_mem_read     out  1          head load
//  out_mem_write    out  1          head store
//  redirect_valid   out  1          one-cycle taken-branch pulse
//  redirect_pc      out  REG_WIDTH  branch target
//  fwd_valid        out  1          out_valid & out_reg_write & !out_mem_read
//  fwd_rd           out  5          = out_rd
//  fwd_data         out  REG_WIDTH  = out_alu_out
// BEHAVIOUR
//  - Reset: count=0, every out_* and redirect_* = 0, fwd_valid=0, in_ready=1 on the next cycle.
//  - Accept = in_valid & in_ready. Deliver = out_valid & out_ready.
//  - Latency 1 cycle: an entry accepted into an empty stage is visible on out_* the next cycle.
//  - Occupancy FSM:
//      EMPTY(0) -accept-> ONE.
//      ONE: accept & !deliver -> TWO; deliver & !accept -> EMPTY; both -> ONE.
//      TWO: deliver -> ONE. Accept is impossible because in_ready=0.
//  - Ordering: strict FIFO. The head is always the oldest entry; skid entry moves to head on deliver.
//  - Outputs stay stable while out_valid & !out_ready.
//  - Capture rules:
//      in_rd==0 forces stored reg_write=0.
//      in_mem_read & in_mem_write both set: store as mem_write only.
//  - Branch (in_branch=1):
//      Never enters the buffer. Accepted whenever in_ready=1.
//      If in_is_less_than=1: redirect_valid=1 the next cycle for exactly one cycle, with
//      redirect_pc = in_pc + in_imm (mod 2^REG_WIDTH, wraps silently).
//      Not-taken branch: no output activity.
//  - Flush:
//      Next cycle count=0, out_valid=0, redirect_valid=0, regardless of deliver.
//      An input accepted in the flush cycle is discarded.
//      A deliver coincident with flush still completes at MEM in that cycle.
//  - Reset mid-operation: identical to flush, plus in_ready=1 next cycle. Reset wins over flush.
//  - out_* data fields are don't-care when out_valid=0; control fields are forced 0.
// TESTING
//  1. Reset, then accept {alu=0x10, rd=5, rw=1} with out_ready=1 -> next cycle out_valid=1,
//     out_alu_out=0x10, fwd_valid=1, fwd_rd=5.
//  2. out_ready=0, accept 3 back-to-back entries -> in_ready=0 after the 2nd. The 3rd is held
//     upstream. Raise out_ready -> entries emerge in order 1,2,3 with no loss or duplication.
//  3. Branch in_pc=0x100, in_imm=0xFFFFFFF0, is_less_than=1 -> redirect_valid for 1 cycle,
//     redirect_pc=0xF0, out_valid stays 0. With is_less_than=0 -> no redirect.
//  4. Stage full (count=2), assert flush together with in_valid -> next cycle out_valid=0,
//     in_ready=1, no redirect; the flushed inputs never appear.
//  5. in_rd=0, in_reg_write=1 -> out_reg_write=0, fwd_valid=0. Load entry (mem_read=1, rw=1)
//     -> fwd_valid=0.
//  6. Random in_valid/out_ready over 10k cycles against a FIFO model, with flush and reset
//     injected -> output sequence matches the model exactly.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// EX->MEM stage bus: upstream instruction channel and downstream valid/ready channel.
// The stage side uses the slave modport; the EX/MEM environment uses master.
interface ex_mem_stage_if #(
  parameter int REG_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [REG_WIDTH-1:0] in_alu_out;
  logic                 in_is_less_than;
  logic [REG_WIDTH-1:0] in_rs2_data;
  logic [4:0]           in_rd;
  logic                 in_reg_write;
  logic                 in_mem_read;
  logic                 in_mem_write;
  logic                 in_branch;
  logic [REG_WIDTH-1:0] in_pc;
  logic [REG_WIDTH-1:0] in_imm;

  logic                 out_valid;
  logic                 out_ready;
  logic [REG_WIDTH-1:0] out_alu_out;
  logic [REG_WIDTH-1:0] out_rs2_data;
  logic [4:0]           out_rd;
  logic                 out_reg_write;
  logic                 out_mem_read;
  logic                 out_mem_write;

  modport master (
    output in_valid, in_alu_out, in_is_less_than, in_rs2_data, in_rd,
           in_reg_write, in_mem_read, in_mem_write, in_branch, in_pc, in_imm,
           out_ready,
    input  in_ready, out_valid, out_alu_out, out_rs2_data, out_rd,
           out_reg_write, out_mem_read, out_mem_write
  );

  modport slave (
    input  in_valid, in_alu_out, in_is_less_than, in_rs2_data, in_rd,
           in_reg_write, in_mem_read, in_mem_write, in_branch, in_pc, in_imm,
           out_ready,
    output in_ready, out_valid, out_alu_out, out_rs2_data, out_rd,
           out_reg_write, out_mem_read, out_mem_write
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline stage: 2-entry skid buffer toward MEM, blt redirect pulse,
// and the EX-side forwarding tap taken from the head entry.
module ex_mem_stage #(
  parameter int REG_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  ex_mem_stage_if.slave        bus,
  output logic                 redirect_valid,
  output logic [REG_WIDTH-1:0] redirect_pc,
  output logic                 fwd_valid,
  output logic [4:0]           fwd_rd,
  output logic [REG_WIDTH-1:0] fwd_data
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [REG_WIDTH-1:0] alu_out;
    logic [REG_WIDTH-1:0] rs2_data;
    logic [4:0]           rd;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
  } entry_t;

  occ_e                 r_state;
  occ_e                 w_state_nxt;
  entry_t               r_head;
  entry_t               r_skid;
  entry_t               w_head_nxt;
  entry_t               w_skid_nxt;
  entry_t               w_in_entry;
  logic                 r_in_ready;
  logic                 r_redirect_valid;
  logic [REG_WIDTH-1:0] r_redirect_pc;

  logic w_accept;
  logic w_accept_entry;
  logic w_taken;
  logic w_out_valid;
  logic w_deliver;

  // Branches are consumed here and never occupy a buffer slot.
  assign w_accept       = bus.in_valid & r_in_ready;
  assign w_accept_entry = w_accept & ~bus.in_branch;
  assign w_taken        = w_accept & bus.in_branch & bus.in_is_less_than & ~flush;
  assign w_out_valid    = (r_state != EMPTY);
  assign w_deliver      = w_out_valid & bus.out_ready;

  // x0 is never written; a load+store combination is treated as a pure store.
  always_comb begin
    w_in_entry.alu_out   = bus.in_alu_out;
    w_in_entry.rs2_data  = bus.in_rs2_data;
    w_in_entry.rd        = bus.in_rd;
    w_in_entry.reg_write = bus.in_reg_write & (bus.in_rd != 5'd0);
    w_in_entry.mem_read  = bus.in_mem_read & ~bus.in_mem_write;
    w_in_entry.mem_write = bus.in_mem_write;
  end

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_skid_nxt  = r_skid;
    unique case (r_state)
      EMPTY: begin
        if (w_accept_entry) begin
          w_head_nxt  = w_in_entry;
          w_state_nxt = ONE;
        end
      end
      ONE: begin
        if (w_accept_entry && w_deliver) begin
          w_head_nxt = w_in_entry;
        end else if (w_accept_entry) begin
          w_skid_nxt  = w_in_entry;
          w_state_nxt = TWO;
        end else if (w_deliver) begin
          w_state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (w_deliver) begin
          w_head_nxt  = r_skid;
          w_state_nxt = ONE;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
    // A flush drops everything held; a deliver in this cycle still completes at MEM.
    if (flush) begin
      w_state_nxt = EMPTY;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the two entry slots are reset as well because out_* must read zero after reset.
      r_state          <= EMPTY;
      r_head           <= '0;
      r_skid           <= '0;
      r_in_ready       <= 1'b1;
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_head           <= w_head_nxt;
      r_skid           <= w_skid_nxt;
      r_in_ready       <= (w_state_nxt != TWO);
      r_redirect_valid <= w_taken;
      if (w_taken) begin
        r_redirect_pc <= bus.in_pc + bus.in_imm;
      end
    end
  end

  assign bus.in_ready      = r_in_ready;
  assign bus.out_valid     = w_out_valid;
  assign bus.out_alu_out   = r_head.alu_out;
  assign bus.out_rs2_data  = r_head.rs2_data;
  assign bus.out_rd        = r_head.rd;
  assign bus.out_reg_write = r_head.reg_write & w_out_valid;
  assign bus.out_mem_read  = r_head.mem_read & w_out_valid;
  assign bus.out_mem_write = r_head.mem_write & w_out_valid;

  assign redirect_valid = r_redirect_valid;
  assign redirect_pc    = r_redirect_pc;

  // Loads forward nothing here: their data only exists after MEM.
  assign fwd_valid = w_out_valid & r_head.reg_write & ~r_head.mem_read;
  assign fwd_rd    = r_head.rd;
  assign fwd_data  = r_head.alu_out;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic with flush/reset.
module tb_ex_mem_stage;
  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         fwd_valid;
  logic [4:0]   fwd_rd;
  logic [W-1:0] fwd_data;

  int n_checks = 0;
  int n_fail   = 0;

  ex_mem_stage_if #(.REG_WIDTH(W)) bus ();

  ex_mem_stage #(.REG_WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .flush          (flush),
    .bus            (bus),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fwd_valid      (fwd_valid),
    .fwd_rd         (fwd_rd),
    .fwd_data       (fwd_data)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] alu;
    logic [W-1:0] rs2;
    logic [4:0]   rd;
    logic         rw;
    logic         mr;
    logic         mw;
  } ent_t;

  // Reference model: the stage is a FIFO of at most two entries plus a redirect flag.
  ent_t         m_q[$];
  bit           m_live = 0;
  bit           m_ready;
  bit           m_redir;
  logic [W-1:0] m_redir_pc;
  bit           m_acc, m_del, m_taken;
  ent_t         m_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clock) begin
    if (reset) begin
      m_q.delete();
      m_ready = 1;
      m_redir = 0;
      m_live  = 1;
    end else if (m_live) begin
      m_acc   = bus.in_valid && m_ready;
      m_del   = (m_q.size() > 0) && bus.out_ready;
      m_taken = m_acc && bus.in_branch && bus.in_is_less_than && !flush;
      m_e.alu = bus.in_alu_out;
      m_e.rs2 = bus.in_rs2_data;
      m_e.rd  = bus.in_rd;
      m_e.rw  = bus.in_reg_write && (bus.in_rd != 0);
      m_e.mr  = bus.in_mem_read && !bus.in_mem_write;
      m_e.mw  = bus.in_mem_write;
      if (m_del) void'(m_q.pop_front());
      if (flush) m_q.delete();
      else if (m_acc && !bus.in_branch) m_q.push_back(m_e);
      m_ready = (m_q.size() < 2);
      m_redir = m_taken;
      if (m_taken) m_redir_pc = bus.in_pc + bus.in_imm;
    end
  end

  // Compare process: DUT outputs against the model, sampled mid-cycle.
  always @(negedge clock) begin
    if (m_live) begin
      bit   v;
      ent_t h;
      v = (m_q.size() > 0);
      if (v) h = m_q[0];
      check("in_ready", 64'(bus.in_ready), 64'(m_ready));
      check("out_valid", 64'(bus.out_valid), 64'(v));
      check("redirect_valid", 64'(redirect_valid), 64'(m_redir));
      check("out_reg_write", 64'(bus.out_reg_write), 64'(v && h.rw));
      check("out_mem_read", 64'(bus.out_mem_read), 64'(v && h.mr));
      check("out_mem_write", 64'(bus.out_mem_write), 64'(v && h.mw));
      check("fwd_valid", 64'(fwd_valid), 64'(v && h.rw && !h.mr));
      if (v) begin
        check("out_alu_out", 64'(bus.out_alu_out), 64'(h.alu));
        check("out_rs2_data", 64'(bus.out_rs2_data), 64'(h.rs2));
        check("out_rd", 64'(bus.out_rd), 64'(h.rd));
        check("fwd_rd", 64'(fwd_rd), 64'(h.rd));
        check("fwd_data", 64'(fwd_data), 64'(h.alu));
      end
      if (m_redir) check("redirect_pc", 64'(redirect_pc), 64'(m_redir_pc));
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.in_valid        = 0;
    bus.in_alu_out      = '0;
    bus.in_is_less_than = 0;
    bus.in_rs2_data     = '0;
    bus.in_rd           = '0;
    bus.in_reg_write    = 0;
    bus.in_mem_read     = 0;
    bus.in_mem_write    = 0;
    bus.in_branch       = 0;
    bus.in_pc           = '0;
    bus.in_imm          = '0;
  endtask

  task automatic put(input logic [W-1:0] alu, input logic [4:0] rd, input logic rw,
                     input logic mr, input logic mw);
    idle();
    bus.in_valid     = 1;
    bus.in_alu_out   = alu;
    bus.in_rs2_data  = ~alu;
    bus.in_rd        = rd;
    bus.in_reg_write = rw;
    bus.in_mem_read  = mr;
    bus.in_mem_write = mw;
  endtask

  task automatic put_branch(input logic [W-1:0] pc, input logic [W-1:0] imm, input logic lt);
    idle();
    bus.in_valid        = 1;
    bus.in_branch       = 1;
    bus.in_pc           = pc;
    bus.in_imm          = imm;
    bus.in_is_less_than = lt;
  endtask

  initial begin
    idle();
    bus.out_ready = 0;
    reset = 1;
    step();
    step();
    reset = 0;
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst out_alu_out", 64'(bus.out_alu_out), 64'd0);
    check("rst redirect_valid", 64'(redirect_valid), 64'd0);
    check("rst fwd_valid", 64'(fwd_valid), 64'd0);

    // Single entry, one-cycle latency.
    bus.out_ready = 1;
    put(32'h10, 5'd5, 1, 0, 0);
    step();
    idle();
    check("t1 out_valid", 64'(bus.out_valid), 64'd1);
    check("t1 out_alu_out", 64'(bus.out_alu_out), 64'h10);
    check("t1 fwd_valid", 64'(fwd_valid), 64'd1);
    check("t1 fwd_rd", 64'(fwd_rd), 64'd5);
    step();
    check("t1 drained", 64'(bus.out_valid), 64'd0);

    // Back-pressure: two fill the stage, the third waits upstream.
    bus.out_ready = 0;
    put(32'd1, 5'd1, 1, 0, 0);
    step();
    put(32'd2, 5'd2, 1, 0, 0);
    step();
    check("t2 full in_ready", 64'(bus.in_ready), 64'd0);
    put(32'd3, 5'd3, 1, 0, 0);
    step();
    check("t2 held in_ready", 64'(bus.in_ready), 64'd0);
    check("t2 head 1", 64'(bus.out_alu_out), 64'd1);
    bus.out_ready = 1;
    step();
    check("t2 head 2", 64'(bus.out_alu_out), 64'd2);
    step();
    idle();
    check("t2 head 3", 64'(bus.out_alu_out), 64'd3);
    step();
    check("t2 empty", 64'(bus.out_valid), 64'd0);

    // Taken branch with wrapping target, then not-taken.
    put_branch(32'h100, 32'hFFFF_FFF0, 1);
    step();
    idle();
    check("t3 redirect_valid", 64'(redirect_valid), 64'd1);
    check("t3 redirect_pc", 64'(redirect_pc), 64'hF0);
    check("t3 out_valid", 64'(bus.out_valid), 64'd0);
    step();
    check("t3 pulse ends", 64'(redirect_valid), 64'd0);
    put_branch(32'h100, 32'hFFFF_FFF0, 0);
    step();
    idle();
    check("t3 not taken", 64'(redirect_valid), 64'd0);

    // Flush while full, with a pending input.
    bus.out_ready = 0;
    put(32'hA, 5'd6, 1, 0, 0);
    step();
    put(32'hB, 5'd7, 1, 0, 0);
    step();
    check("t4 full", 64'(bus.in_ready), 64'd0);
    put(32'hDEAD, 5'd8, 1, 0, 0);
    flush = 1;
    step();
    flush = 0;
    idle();
    check("t4 out_valid", 64'(bus.out_valid), 64'd0);
    check("t4 in_ready", 64'(bus.in_ready), 64'd1);
    check("t4 redirect", 64'(redirect_valid), 64'd0);
    bus.out_ready = 1;
    step();
    check("t4 nothing appears", 64'(bus.out_valid), 64'd0);

    // Capture rules: rd==0, load, load+store.
    put(32'h55, 5'd0, 1, 0, 0);
    step();
    check("t5 rd0 valid", 64'(bus.out_valid), 64'd1);
    check("t5 rd0 reg_write", 64'(bus.out_reg_write), 64'd0);
    check("t5 rd0 fwd_valid", 64'(fwd_valid), 64'd0);
    put(32'h66, 5'd3, 1, 1, 0);
    step();
    check("t5 load mem_read", 64'(bus.out_mem_read), 64'd1);
    check("t5 load fwd_valid", 64'(fwd_valid), 64'd0);
    put(32'h77, 5'd4, 0, 1, 1);
    step();
    idle();
    check("t5 rw mem_read", 64'(bus.out_mem_read), 64'd0);
    check("t5 rw mem_write", 64'(bus.out_mem_write), 64'd1);
    step();

    // Randomized traffic with occasional flush and reset.
    for (int i = 0; i < 10000; i++) begin
      reset               = ($urandom_range(0, 99) == 0);
      flush               = ($urandom_range(0, 49) == 0);
      bus.in_valid        = ($urandom_range(0, 9) < 6);
      bus.out_ready       = ($urandom_range(0, 9) < 6);
      bus.in_branch       = ($urandom_range(0, 4) == 0);
      bus.in_is_less_than = $urandom_range(0, 1);
      bus.in_alu_out      = $urandom;
      bus.in_rs2_data     = $urandom;
      bus.in_rd           = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      bus.in_reg_write    = $urandom_range(0, 1);
      bus.in_mem_read     = $urandom_range(0, 1);
      bus.in_mem_write    = ($urandom_range(0, 3) == 0);
      bus.in_pc           = $urandom;
      bus.in_imm          = $urandom;
      step();
    end
    reset = 0;
    flush = 0;
    idle();
    bus.out_ready = 1;
    repeat (4) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
